// File: rtl/rf_serial_pkg.sv
// rf_serial_pkg
// Constants shared by both ends of the serial RF link (emitter and receptor).
// The frame format is an 8-bit sync word followed by 8 data bits.
// Both fields are sent LSB first, and the line idles low.
// Contents: default bit period, sync word, field length, framing state
// encoding, and the LSB-first shift helper.
package rf_serial_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 8333334;
  localparam logic [7:0]  SYNC_WORD_DEF    = 8'hFF;
  localparam int unsigned FIELD_BITS       = 8;

  // Framing states; numeric values are shared with existing tooling.
  localparam logic [1:0] ST_HUNT     = 2'd0;
  localparam logic [1:0] ST_DATA     = 2'd1;
  localparam logic [1:0] ST_SYNC_CHK = 2'd2;

  // The first bit received ends up in bit 0 after eight shifts.
  function automatic logic [7:0] shift_lsb_first(input logic [7:0] sr,
                                                 input logic       b);
    return {b, sr[7:1]};
  endfunction

endpackage

// File: rtl/muestreo_bit.sv
// muestreo_bit
// Recovers bit timing from the asynchronous serial line.
// The line passes through a 2-flop synchronizer, and a third flop provides
// edge detection.
// A phase counter is re-zeroed on every line edge and otherwise wraps every
// CLKS_PER_BIT cycles. The sample strobe fires when the counter reaches
// mid-bit.
// Ports:
//   Clk           in   system clock
//   Rst           in   synchronous reset, active high
//   Serial_Bit_In in   asynchronous serial line
//   bit_s         out  synchronized line level
//   strobe        out  one-cycle pulse at the centre of each bit
module muestreo_bit
  import rf_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned CNT_W        = 32
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Serial_Bit_In,
  output logic bit_s,
  output logic strobe
);

  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PH_MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] PH_ONE  = CNT_W'(1);

  logic             sync_p0;
  logic             sync_p1;
  logic             sync_p2;
  logic             line_edge;
  logic [CNT_W-1:0] ph;

  // Stage p0/p1: metastability synchronizer; p2: previous level for edge detect
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= Serial_Bit_In;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign line_edge = sync_p1 ^ sync_p2;

  // Phase counter: an edge re-aligns the bit boundary and wins over the wrap
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ph <= '0;
    end else if (line_edge) begin
      ph <= '0;
    end else if (ph == PH_LAST) begin
      ph <= '0;
    end else begin
      ph <= ph + PH_ONE;
    end
  end

  assign bit_s  = sync_p1;
  assign strobe = (ph == PH_MID);

endmodule

// File: rtl/receptor_serial.sv
// receptor_serial
// Receiving end of the serial RF link.
// It hunts the bit stream for the sync word and locks onto the frame. It then
// delivers each data byte with a one-cycle valid pulse. The sync field of
// every frame is checked, and alignment drops on a mismatch.
// Ports:
//   Clk           in   system clock
//   Rst           in   synchronous reset, active high
//   Serial_Bit_In in   asynchronous serial line from the RF receiver
//   Dato_Out      out  last received data byte (held between pulses)
//   Dato_Valid    out  one-cycle pulse when Dato_Out updates
//   Locked        out  high while frame alignment is established
//   Sync_Err      out  one-cycle pulse when an expected sync word mismatches
module receptor_serial
  import rf_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter logic [7:0]  SYNC_WORD    = SYNC_WORD_DEF,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Serial_Bit_In,
  output logic [7:0] Dato_Out,
  output logic       Dato_Valid,
  output logic       Locked,
  output logic       Sync_Err
);

  localparam logic [3:0] FIELD_LAST = 4'(FIELD_BITS);

  logic       bit_s;
  logic       strobe;
  logic [1:0] state;
  logic [3:0] bcnt;
  logic [3:0] bcnt_inc;
  logic [7:0] sr;
  logic [7:0] sr_next;

  muestreo_bit #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_muestreo (
    .Clk           (Clk),
    .Rst           (Rst),
    .Serial_Bit_In (Serial_Bit_In),
    .bit_s         (bit_s),
    .strobe        (strobe)
  );

  // Decisions are made on the post-shift value so that the byte completed by
  // this strobe is visible in the same cycle.
  assign sr_next  = shift_lsb_first(sr, bit_s);
  assign bcnt_inc = bcnt + 4'd1;

  // Framing stage: FSM and output registers, advancing only on sample strobes
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_HUNT;
      bcnt       <= 4'd0;
      sr         <= 8'h00;
      Dato_Out   <= 8'h00;
      Dato_Valid <= 1'b0;
      Sync_Err   <= 1'b0;
    end else begin
      Dato_Valid <= 1'b0;
      Sync_Err   <= 1'b0;
      if (strobe) begin
        sr <= sr_next;
        case (state)
          ST_HUNT: begin
            // Only a full byte received since entering HUNT can qualify.
            // The counter saturates so that a long hunt does not wrap.
            if ((bcnt_inc >= FIELD_LAST) && (sr_next == SYNC_WORD)) begin
              state <= ST_DATA;
              bcnt  <= 4'd0;
            end else if (bcnt != FIELD_LAST) begin
              bcnt <= bcnt_inc;
            end
          end
          ST_DATA: begin
            if (bcnt_inc == FIELD_LAST) begin
              state      <= ST_SYNC_CHK;
              bcnt       <= 4'd0;
              Dato_Out   <= sr_next;
              Dato_Valid <= 1'b1;
            end else begin
              bcnt <= bcnt_inc;
            end
          end
          ST_SYNC_CHK: begin
            if (bcnt_inc == FIELD_LAST) begin
              bcnt <= 4'd0;
              if (sr_next == SYNC_WORD) begin
                state <= ST_DATA;
              end else begin
                // The rejected bits must not count toward a new match.
                state    <= ST_HUNT;
                Sync_Err <= 1'b1;
              end
            end else begin
              bcnt <= bcnt_inc;
            end
          end
          default: begin
            state <= ST_HUNT;
            bcnt  <= 4'd0;
          end
        endcase
      end
    end
  end

  assign Locked = (state != ST_HUNT);

endmodule

// File: tb/tb_receptor_serial.sv
module tb_receptor_serial;
  import rf_serial_pkg::*;

  localparam int CPB = 16;
  localparam logic [7:0] SYNC = 8'hFF;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Serial_Bit_In = 1'b0;
  logic [7:0] Dato_Out;
  logic       Dato_Valid;
  logic       Locked;
  logic       Sync_Err;

  receptor_serial #(
    .CLKS_PER_BIT (CPB),
    .SYNC_WORD    (SYNC),
    .CNT_W        (8)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Serial_Bit_In (Serial_Bit_In),
    .Dato_Out      (Dato_Out),
    .Dato_Valid    (Dato_Valid),
    .Locked        (Locked),
    .Sync_Err      (Sync_Err)
  );

  always #10 Clk = ~Clk;

  // Free-running monitor: cumulative logs, tests take snapshots and deltas.
  int         cyc = 0;
  logic [7:0] vlog[$];
  int         vcyc[$];
  int         err_tot = 0;
  int         fall_tot = 0;
  int         lkhi_tot = 0;
  logic       lk_prev = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Dato_Valid) begin
      vlog.push_back(Dato_Out);
      vcyc.push_back(cyc);
    end
    if (Sync_Err) err_tot <= err_tot + 1;
    if (lk_prev && !Locked) fall_tot <= fall_tot + 1;
    if (Locked) lkhi_tot <= lkhi_tot + 1;
    lk_prev <= Locked;
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    chk_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    Serial_Bit_In = b;
    tick(n);
  endtask

  int per_a = CPB;
  int per_b = CPB;
  bit per_sel = 1'b0;
  int bit7_cyc = 0;

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) bit7_cyc = cyc;
      send_bit(b[i], per_sel ? per_b : per_a);
      per_sel = ~per_sel;
    end
  endtask

  task automatic do_reset(input int n);
    Serial_Bit_In = 1'b0;
    Rst = 1'b1;
    tick(n);
    Rst = 1'b0;
  endtask

  // Reference model: parse the transmitted bit list by frame rules.
  function automatic logic [7:0] byte_at(input logic bq[$], input int s);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = bq[s + k];
    return r;
  endfunction

  function automatic int model(input logic bq[$], output logic [7:0] vals[$]);
    int errs = 0;
    int hs = 0;
    int j;
    int found;
    bit done = 1'b0;
    bit rehunt;
    vals = {};
    while (!done) begin
      found = -1;
      for (int k = hs + 7; k < bq.size(); k++) begin
        if (byte_at(bq, k - 7) == SYNC) begin
          found = k;
          break;
        end
      end
      if (found < 0) begin
        done = 1'b1;
      end else begin
        j = found;
        rehunt = 1'b0;
        while (!done && !rehunt) begin
          if (j + 8 >= bq.size()) done = 1'b1;
          else begin
            vals.push_back(byte_at(bq, j + 1));
            if (j + 16 >= bq.size()) done = 1'b1;
            else if (byte_at(bq, j + 9) == SYNC) j = j + 16;
            else begin
              errs++;
              hs = j + 17;
              rehunt = 1'b1;
            end
          end
        end
      end
    end
    return errs;
  endfunction

  typedef struct {
    int              nb;
    logic [4:0][7:0] by;
    int              pa;
    int              pb;
    int              nv;
    logic [1:0][7:0] ev;
    int              nerr;
    int              nfall;
    bit              lat;
  } vec_t;

  function automatic vec_t mk(input int nb, input logic [39:0] by, input int pa,
                              input int pb, input int nv, input logic [15:0] ev,
                              input int nerr, input int nfall, input bit lat);
    vec_t v;
    v.nb = nb; v.by = by; v.pa = pa; v.pb = pb; v.nv = nv;
    v.ev = ev; v.nerr = nerr; v.nfall = nfall; v.lat = lat;
    return v;
  endfunction

  initial begin
    #(100000 * 20);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vt[4];
    int         v0, e0, f0, h0, nv, lat_ref;
    logic       bq[$];
    logic [7:0] mv[$];
    logic [7:0] s, d;
    int         merr;

    vt[0] = mk(2, {24'h0, 8'hA5, 8'hFF}, 16, 16, 1, {8'h00, 8'hA5}, 0, 0, 1'b1);
    vt[1] = mk(5, {8'hFF, 8'h81, 8'hFF, 8'h3C, 8'hFF}, 16, 16, 2, {8'h81, 8'h3C}, 0, 0, 1'b0);
    vt[2] = mk(5, {8'hC3, 8'hFF, 8'hFE, 8'h55, 8'hFF}, 16, 16, 2, {8'hC3, 8'h55}, 1, 1, 1'b0);
    vt[3] = mk(2, {24'h0, 8'h0F, 8'hFF}, 13, 19, 1, {8'h00, 8'h0F}, 0, 0, 1'b0);

    // Reset state, then idle-low line
    tick(1);
    do_reset(3);
    chk("rst_dato", Dato_Out, 0);
    chk("rst_valid", Dato_Valid, 0);
    chk("rst_locked", Locked, 0);
    chk("rst_syncerr", Sync_Err, 0);
    v0 = vlog.size(); h0 = lkhi_tot;
    tick(400);
    chk("idle_nvalid", vlog.size() - v0, 0);
    chk("idle_lockcycles", lkhi_tot - h0, 0);
    chk("idle_dato", Dato_Out, 0);

    // Directed frame table
    for (int r = 0; r < 4; r++) begin
      do_reset(2);
      tick(3 * CPB);
      per_a = vt[r].pa; per_b = vt[r].pb; per_sel = 1'b0;
      v0 = vlog.size(); e0 = err_tot; f0 = fall_tot;
      lat_ref = 0;
      for (int b = 0; b < vt[r].nb; b++) begin
        send_byte(vt[r].by[b]);
        if (b == 0) chk($sformatf("row%0d_lock_after_sync", r), Locked, 1);
        if (b == 1) lat_ref = bit7_cyc;
      end
      tick(2);
      nv = vlog.size() - v0;
      chk($sformatf("row%0d_nvalid", r), nv, vt[r].nv);
      for (int k = 0; k < vt[r].nv; k++)
        if (k < nv) chk($sformatf("row%0d_val%0d", r, k), vlog[v0 + k], vt[r].ev[k]);
      chk($sformatf("row%0d_syncerr", r), err_tot - e0, vt[r].nerr);
      chk($sformatf("row%0d_lockfalls", r), fall_tot - f0, vt[r].nfall);
      chk($sformatf("row%0d_locked_end", r), Locked, 1);
      chk($sformatf("row%0d_dato_hold", r), Dato_Out, vt[r].ev[vt[r].nv - 1]);
      if (vt[r].lat && nv >= 1)
        chk_rng($sformatf("row%0d_latency", r), vcyc[v0] - lat_ref, 10, 13);
    end

    // Reset during data bit 4 of FF,99, then FF,66
    per_a = CPB; per_b = CPB; per_sel = 1'b0;
    do_reset(2);
    tick(3 * CPB);
    v0 = vlog.size();
    send_byte(8'hFF);
    chk("mid_lock_before_rst", Locked, 1);
    d = 8'h99;
    for (int i = 0; i < 4; i++) send_bit(d[i], CPB);
    Serial_Bit_In = d[4];
    tick(CPB / 2);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    chk("mid_rst_dato", Dato_Out, 0);
    chk("mid_rst_valid", Dato_Valid, 0);
    chk("mid_rst_locked", Locked, 0);
    chk("mid_rst_syncerr", Sync_Err, 0);
    send_bit(1'b0, 2 * CPB);
    chk("mid_no_99_pulse", vlog.size() - v0, 0);
    e0 = err_tot;
    send_byte(8'hFF);
    send_byte(8'h66);
    tick(2);
    chk("mid_nvalid", vlog.size() - v0, 1);
    if (vlog.size() > v0) chk("mid_val", vlog[v0], 8'h66);
    chk("mid_dato", Dato_Out, 8'h66);
    chk("mid_syncerr", err_tot - e0, 0);

    // Randomized streams against the frame-level model
    for (int run = 0; run < 4; run++) begin
      do_reset(2);
      tick(3 * CPB);
      bq = {};
      d = 8'($urandom);
      for (int k = 0; k < 8; k++) bq.push_back(d[k]);
      for (int f = 0; f < 6; f++) begin
        s = (f == 0 || $urandom_range(0, 3) != 0) ? SYNC : 8'($urandom);
        d = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
        for (int k = 0; k < 8; k++) bq.push_back(s[k]);
        for (int k = 0; k < 8; k++) bq.push_back(d[k]);
      end
      merr = model(bq, mv);
      v0 = vlog.size(); e0 = err_tot;
      foreach (bq[k]) send_bit(bq[k], CPB);
      tick(2);
      nv = vlog.size() - v0;
      chk($sformatf("rnd%0d_nvalid", run), nv, mv.size());
      for (int k = 0; k < mv.size(); k++)
        if (k < nv) chk($sformatf("rnd%0d_val%0d", run, k), vlog[v0 + k], mv[k]);
      chk($sformatf("rnd%0d_syncerr", run), err_tot - e0, merr);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
